// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the ID/EX hazard controller and its counters.
// Holds the controller state encoding and the bubble-latency bounds.
package pipeline_hazard_controller_pkg;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_LOAD_STALL = 1'b1
    } hz_state_t;

    localparam int REMAIN_W         = 3;
    localparam int MIN_LOAD_LATENCY = 1;
    localparam int MAX_LOAD_LATENCY = 7;

    function automatic logic load_latency_ok(input int lat);
        return (lat >= MIN_LOAD_LATENCY) && (lat <= MAX_LOAD_LATENCY);
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module hazard_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline write-enable / flush control for load-use stalls, EX redirects and data-RAM freezes.
// Outputs are combinational from state and inputs; only the stall state and perf counters are registered.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_LATENCY   = 1,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_address,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_address,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_address,
    input  logic                      ex_reg_wren,
    input  logic                      ex_is_load,
    input  logic                      ex_redirect,
    input  logic                      mem_busy,
    output logic                      pc_wren,
    output logic                      if_id_wren,
    output logic                      id_ex_wren,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      stall_active,
    output logic [PERF_CNT_WIDTH-1:0] stall_cycle_count,
    output logic [PERF_CNT_WIDTH-1:0] flush_count
);

    if (!load_latency_ok(LOAD_LATENCY)) begin : g_bad_load_latency
        $error("pipeline_hazard_controller: LOAD_LATENCY must be 1..7");
    end

    hz_state_t           state, state_nxt;
    logic [REMAIN_W-1:0] remaining, remaining_nxt;
    logic                hazard;
    logic                flush_taken;

    assign hazard = ex_is_load && ex_reg_wren && (ex_rd_address != '0) &&
                    ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
                     (id_uses_rs2 && (id_rs2_address == ex_rd_address)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pc_wren       = 1'b0;
        if_id_wren    = 1'b0;
        id_ex_wren    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        flush_taken   = 1'b0;
        // A busy data RAM freezes everything, including the stall countdown.
        if (!reset && !mem_busy) begin
            if (ex_redirect) begin
                pc_wren       = 1'b1;
                if_id_wren    = 1'b1;
                id_ex_wren    = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                flush_taken   = 1'b1;
                state_nxt     = ST_RUN;
                remaining_nxt = '0;
            end else if ((state == ST_LOAD_STALL) || hazard) begin
                id_ex_wren  = 1'b1;
                id_ex_flush = 1'b1;
                if (state == ST_LOAD_STALL) begin
                    if (remaining == REMAIN_W'(1)) begin
                        state_nxt     = ST_RUN;
                        remaining_nxt = '0;
                    end else begin
                        remaining_nxt = remaining - 1'b1;
                    end
                end else if (LOAD_LATENCY > 1) begin
                    state_nxt     = ST_LOAD_STALL;
                    remaining_nxt = REMAIN_W'(LOAD_LATENCY - 1);
                end
            end else begin
                pc_wren    = 1'b1;
                if_id_wren = 1'b1;
                id_ex_wren = 1'b1;
            end
        end
    end

    assign stall_active = !reset && !pc_wren;

    hazard_perf_counter #(
        .WIDTH (PERF_CNT_WIDTH)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_active),
        .count (stall_cycle_count)
    );

    hazard_perf_counter #(
        .WIDTH (PERF_CNT_WIDTH)
    ) u_flush_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_taken),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (LAT=1/PCW=32 and LAT=3/PCW=4) share stimulus
// and are checked every cycle against a behavioural model, plus hand-computed directed expectations.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic       id_uses_rs1, id_uses_rs2, ex_reg_wren, ex_is_load, ex_redirect, mem_busy;

    logic        pc_a, ifid_a, idex_a, iff_a, idf_a, sa_a;
    logic [31:0] scnt_a, fcnt_a;
    logic        pc_b, ifid_b, idex_b, iff_b, idf_b, sa_b;
    logic [3:0]  scnt_b, fcnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state per instance: bubbles still owed, counter values.
    int     m_rem  [2];
    longint m_scnt [2];
    longint m_fcnt [2];
    int     m_lat  [2];
    longint m_max  [2];

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_ADDR_WIDTH (5),
        .LOAD_LATENCY   (1),
        .PERF_CNT_WIDTH (32)
    ) dut_a (
        .clk               (clk),
        .reset             (reset),
        .id_rs1_address    (id_rs1_address),
        .id_rs2_address    (id_rs2_address),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .ex_rd_address     (ex_rd_address),
        .ex_reg_wren       (ex_reg_wren),
        .ex_is_load        (ex_is_load),
        .ex_redirect       (ex_redirect),
        .mem_busy          (mem_busy),
        .pc_wren           (pc_a),
        .if_id_wren        (ifid_a),
        .id_ex_wren        (idex_a),
        .if_id_flush       (iff_a),
        .id_ex_flush       (idf_a),
        .stall_active      (sa_a),
        .stall_cycle_count (scnt_a),
        .flush_count       (fcnt_a)
    );

    pipeline_hazard_controller #(
        .REG_ADDR_WIDTH (5),
        .LOAD_LATENCY   (3),
        .PERF_CNT_WIDTH (4)
    ) dut_b (
        .clk               (clk),
        .reset             (reset),
        .id_rs1_address    (id_rs1_address),
        .id_rs2_address    (id_rs2_address),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .ex_rd_address     (ex_rd_address),
        .ex_reg_wren       (ex_reg_wren),
        .ex_is_load        (ex_is_load),
        .ex_redirect       (ex_redirect),
        .mem_busy          (mem_busy),
        .pc_wren           (pc_b),
        .if_id_wren        (ifid_b),
        .id_ex_wren        (idex_b),
        .if_id_flush       (iff_b),
        .id_ex_flush       (idf_b),
        .stall_active      (sa_b),
        .stall_cycle_count (scnt_b),
        .flush_count       (fcnt_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_idle();
        id_rs1_address = 5'd0;
        id_rs2_address = 5'd0;
        id_uses_rs1    = 1'b0;
        id_uses_rs2    = 1'b0;
        ex_rd_address  = 5'd0;
        ex_reg_wren    = 1'b0;
        ex_is_load     = 1'b0;
        ex_redirect    = 1'b0;
        mem_busy       = 1'b0;
    endtask

    // Load to x5 in EX, ID reads x5 via rs1.
    task automatic set_load_use();
        set_idle();
        ex_is_load     = 1'b1;
        ex_reg_wren    = 1'b1;
        ex_rd_address  = 5'd5;
        id_uses_rs1    = 1'b1;
        id_rs1_address = 5'd5;
    endtask

    // Compare both instances against the model for the current inputs, then advance the model
    // to what the upcoming clock edge must produce.
    task automatic model_step();
        logic   hz, stalling;
        logic   e_pc, e_idex, e_iff, e_idf, e_sa;
        logic   a_pc, a_ifid, a_idex, a_iff, a_idf, a_sa;
        longint a_sc, a_fc;
        hz = ex_is_load && ex_reg_wren && (ex_rd_address != 0) &&
             ((id_uses_rs1 && id_rs1_address == ex_rd_address) ||
              (id_uses_rs2 && id_rs2_address == ex_rd_address));
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_rem[m]  = 0;
                m_scnt[m] = 0;
                m_fcnt[m] = 0;
            end
            stalling = !reset && !mem_busy && !ex_redirect && (m_rem[m] > 0 || hz);
            e_pc   = !reset && !mem_busy && !stalling;
            e_idex = !reset && !mem_busy;
            e_iff  = !reset && !mem_busy && ex_redirect;
            e_idf  = e_iff || stalling;
            e_sa   = !reset && !e_pc;
            if (m == 0) begin
                a_pc = pc_a; a_ifid = ifid_a; a_idex = idex_a; a_iff = iff_a; a_idf = idf_a;
                a_sa = sa_a; a_sc = longint'(scnt_a); a_fc = longint'(fcnt_a);
            end else begin
                a_pc = pc_b; a_ifid = ifid_b; a_idex = idex_b; a_iff = iff_b; a_idf = idf_b;
                a_sa = sa_b; a_sc = longint'(scnt_b); a_fc = longint'(fcnt_b);
            end
            chk($sformatf("dut%0d pc_wren", m),      longint'(a_pc),   longint'(e_pc));
            chk($sformatf("dut%0d if_id_wren", m),   longint'(a_ifid), longint'(e_pc));
            chk($sformatf("dut%0d id_ex_wren", m),   longint'(a_idex), longint'(e_idex));
            chk($sformatf("dut%0d if_id_flush", m),  longint'(a_iff),  longint'(e_iff));
            chk($sformatf("dut%0d id_ex_flush", m),  longint'(a_idf),  longint'(e_idf));
            chk($sformatf("dut%0d stall_active", m), longint'(a_sa),   longint'(e_sa));
            chk($sformatf("dut%0d stall_count", m),  a_sc, m_scnt[m]);
            chk($sformatf("dut%0d flush_count", m),  a_fc, m_fcnt[m]);
            if (!reset) begin
                if (e_sa && m_scnt[m] < m_max[m]) m_scnt[m]++;
                if (e_iff && m_fcnt[m] < m_max[m]) m_fcnt[m]++;
                if (!mem_busy) begin
                    if (ex_redirect) m_rem[m] = 0;
                    else if (stalling) m_rem[m] = (m_rem[m] > 0) ? m_rem[m] - 1 : m_lat[m] - 1;
                end
            end
        end
    endtask

    task automatic eval();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_lat[0] = 1;  m_max[0] = 64'hFFFF_FFFF;
        m_lat[1] = 3;  m_max[1] = 64'hF;
        for (int m = 0; m < 2; m++) begin
            m_rem[m] = 0; m_scnt[m] = 0; m_fcnt[m] = 0;
        end
        reset = 1'b1;
        set_idle();

        // Reset state.
        eval();
        chk("reset pc_wren",      longint'(pc_a),   0);
        chk("reset id_ex_wren",   longint'(idex_b), 0);
        chk("reset stall_active", longint'(sa_b),   0);
        chk("reset stall_count",  longint'(scnt_a), 0);
        adv();
        reset = 1'b0;
        eval();
        chk("run pc_wren", longint'(pc_a), 1);
        adv();

        // Load-use, LAT=1 vs LAT=3.
        set_load_use();
        eval();
        chk("lu a pc_wren",     longint'(pc_a),  0);
        chk("lu a id_ex_flush", longint'(idf_a), 1);
        chk("lu b pc_wren",     longint'(pc_b),  0);
        adv();
        set_idle();
        eval();
        chk("lu a resume pc_wren", longint'(pc_a),   1);
        chk("lu a stall_count",    longint'(scnt_a), 1);
        chk("lu b stall2 pc_wren", longint'(pc_b),   0);
        chk("lu b stall2 flush",   longint'(idf_b),  1);
        adv();
        eval();
        chk("lu b stall3 pc_wren", longint'(pc_b), 0);
        adv();
        eval();
        chk("lu b resume pc_wren", longint'(pc_b),   1);
        chk("lu b stall_count",    longint'(scnt_b), 3);
        adv();

        // No-stall boundaries: rd=x0, and unused rs1.
        set_idle();
        ex_is_load = 1'b1; ex_reg_wren = 1'b1; ex_rd_address = 5'd0;
        id_uses_rs2 = 1'b1; id_rs2_address = 5'd0;
        eval();
        chk("x0 no stall", longint'(pc_b), 1);
        adv();
        set_load_use();
        id_uses_rs1 = 1'b0;
        eval();
        chk("unused rs1 no stall", longint'(pc_b), 1);
        adv();

        // Redirect in the second stall cycle of LAT=3.
        set_load_use();
        eval();
        adv();
        set_idle();
        ex_redirect = 1'b1;
        eval();
        chk("redir pc_wren",     longint'(pc_b),  1);
        chk("redir if_id_flush", longint'(iff_b), 1);
        chk("redir id_ex_flush", longint'(idf_b), 1);
        adv();
        set_idle();
        eval();
        chk("redir after pc_wren", longint'(pc_b),   1);
        chk("redir flush_count",   longint'(fcnt_b), 1);
        adv();

        // mem_busy for 4 cycles while 2 bubbles remain.
        set_load_use();
        eval();
        adv();
        set_idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("busy pc_wren",    longint'(pc_b),   0);
            chk("busy id_ex_wren", longint'(idex_b), 0);
            adv();
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            eval();
            chk("post-busy stall pc_wren", longint'(pc_b),  0);
            chk("post-busy stall flush",   longint'(idf_b), 1);
            adv();
        end
        eval();
        chk("post-busy resume", longint'(pc_b), 1);
        adv();

        // Saturation of the 4-bit stall counter.
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            eval();
            adv();
        end
        mem_busy = 1'b0;
        eval();
        chk("sat stall_count", longint'(scnt_b), 15);
        adv();

        // Reset in the middle of LOAD_STALL.
        set_load_use();
        eval();
        adv();
        set_idle();
        eval();
        adv();
        reset = 1'b1;
        eval();
        chk("mid rst pc_wren",     longint'(pc_b),   0);
        chk("mid rst id_ex_flush", longint'(idf_b),  0);
        chk("mid rst stall_count", longint'(scnt_b), 0);
        chk("mid rst flush_count", longint'(fcnt_a), 0);
        adv();
        reset = 1'b0;
        eval();
        chk("after rst no bubble", longint'(pc_b), 1);
        adv();

        // Randomised traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            id_rs1_address = 5'($urandom_range(0, 3));
            id_rs2_address = 5'($urandom_range(0, 3));
            ex_rd_address  = 5'($urandom_range(0, 3));
            id_uses_rs1    = 1'($urandom_range(0, 1));
            id_uses_rs2    = 1'($urandom_range(0, 1));
            ex_reg_wren    = ($urandom_range(0, 3) != 0);
            ex_is_load     = ($urandom_range(0, 2) == 0);
            ex_redirect    = ($urandom_range(0, 9) == 0);
            mem_busy       = ($urandom_range(0, 7) == 0);
            reset          = ($urandom_range(0, 149) == 0);
            eval();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
